// File: rtl/riscv_fetch_aligner.sv
// RISC-V fetch aligner: turns a stream of word-aligned fetch words into aligned
// 16/32-bit instructions with their PCs, including compressed and straddling cases.
module riscv_fetch_aligner #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        fetch_ready_o,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_addr_o,
    output logic        instr_compressed_o
);

    typedef enum logic [1:0] {
        ALIGNED  = 2'd0,
        HALF     = 2'd1,
        SKIP_LOW = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] residual_q, residual_d;
    logic [31:0] pc_q, pc_d;

    logic        valid_raw, ready_raw;
    logic        valid_int, ready_int;
    logic [31:0] rdata;
    logic        rvc;
    logic        xfer, fetch_acc;
    logic [15:0] w_lo, w_hi;

    function automatic logic is_rvc(input logic [15:0] h);
        return h[1:0] != 2'b11;
    endfunction

    assign w_lo = fetch_rdata_i[15:0];
    assign w_hi = fetch_rdata_i[31:16];

    // State register: control and datapath share the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ALIGNED;
            residual_q <= 16'h0000;
            pc_q       <= BOOT_ADDR;
        end else begin
            state_q    <= state_d;
            residual_q <= residual_d;
            pc_q       <= pc_d;
        end
    end

    // Output decode: what can be presented this cycle from residual and fetch word.
    always_comb begin
        valid_raw = 1'b0;
        ready_raw = 1'b0;
        rdata     = 32'h0000_0000;
        case (state_q)
            ALIGNED: begin
                valid_raw = fetch_valid_i;
                ready_raw = fetch_valid_i & instr_ready_i;
                rdata     = is_rvc(w_lo) ? {16'h0000, w_lo} : fetch_rdata_i;
            end
            HALF: begin
                if (is_rvc(residual_q)) begin
                    valid_raw = 1'b1;
                    rdata     = {16'h0000, residual_q};
                end else begin
                    valid_raw = fetch_valid_i;
                    ready_raw = fetch_valid_i & instr_ready_i;
                    rdata     = {w_lo, residual_q};
                end
            end
            SKIP_LOW: begin
                if (is_rvc(w_hi)) begin
                    valid_raw = fetch_valid_i;
                    ready_raw = fetch_valid_i & instr_ready_i;
                    rdata     = {16'h0000, w_hi};
                end else begin
                    // Upper half starts a 32-bit instruction: swallow the word into the residual.
                    ready_raw = fetch_valid_i;
                end
            end
            default: begin
                valid_raw = 1'b0;
                ready_raw = 1'b0;
            end
        endcase
    end

    assign valid_int = valid_raw & ~branch_i;
    assign ready_int = ready_raw & ~branch_i;
    assign rvc       = is_rvc(rdata[15:0]);
    assign xfer      = valid_int & instr_ready_i;
    assign fetch_acc = ready_int & fetch_valid_i;

    // Reset only masks the handshakes at the ports; the flops are already held.
    assign instr_valid_o      = valid_int & rst_n;
    assign fetch_ready_o      = ready_int & rst_n;
    assign instr_rdata_o      = rdata;
    assign instr_compressed_o = rvc;
    assign instr_addr_o       = pc_q;

    // Next-state logic; a redirect overrides any transfer in the same cycle.
    always_comb begin
        state_d    = state_q;
        residual_d = residual_q;
        pc_d       = pc_q;
        if (branch_i) begin
            pc_d       = {branch_addr_i[31:1], 1'b0};
            residual_d = 16'h0000;
            state_d    = branch_addr_i[1] ? SKIP_LOW : ALIGNED;
        end else begin
            if (xfer) begin
                pc_d = pc_q + (rvc ? 32'd2 : 32'd4);
            end
            case (state_q)
                ALIGNED: begin
                    if (xfer && rvc) begin
                        residual_d = w_hi;
                        state_d    = HALF;
                    end
                end
                HALF: begin
                    if (xfer) begin
                        if (is_rvc(residual_q)) begin
                            state_d = ALIGNED;
                        end else begin
                            residual_d = w_hi;
                        end
                    end
                end
                SKIP_LOW: begin
                    if (is_rvc(w_hi)) begin
                        if (xfer) begin
                            state_d = ALIGNED;
                        end
                    end else if (fetch_acc) begin
                        residual_d = w_hi;
                        state_d    = HALF;
                    end
                end
                default: begin
                    state_d = ALIGNED;
                end
            endcase
        end
    end

endmodule

// File: doc/riscv_fetch_aligner.md
RISCV_FETCH_ALIGNER -- requirements
Module: riscv_fetch_aligner

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0080, giving the PC of the first instruction after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port fetch_valid_i, input, 1, fetch word available.
REQ-005 SHALL have port fetch_rdata_i, input, 32, word-aligned fetched data; bits [15:0] are the lower halfword.
REQ-006 SHALL have port fetch_ready_o, output, 1, fetch word consumed this cycle when high together with fetch_valid_i.
REQ-007 SHALL have port branch_i, input, 1, single-cycle redirect strobe.
REQ-008 SHALL have port branch_addr_i, input, 32, redirect target; bit 0 ignored (treated as 0).
REQ-009 SHALL have port instr_valid_o, output, 1, aligned instruction present.
REQ-010 SHALL have port instr_ready_i, input, 1, decoder accepts the instruction.
REQ-011 SHALL have port instr_rdata_o, output, 32, aligned instruction; when compressed, bits [31:16] = 16'h0000.
REQ-012 SHALL have port instr_addr_o, output, 32, PC of instr_rdata_o.
REQ-013 SHALL have port instr_compressed_o, output, 1, high when instr_rdata_o[1:0] != 2'b11.

Function
REQ-014 SHALL hold a state register with states ALIGNED, HALF and SKIP_LOW, a 16-bit residual register and a 32-bit pc register.
REQ-015 SHALL drive instr_valid_o, instr_rdata_o, fetch_ready_o and instr_compressed_o combinationally from the state, the residual, fetch_valid_i and fetch_rdata_i; instr_addr_o = pc; latency zero cycles.
REQ-016 SHALL transfer an instruction only when instr_valid_o and instr_ready_i are both high; on transfer pc SHALL advance by 2 (compressed) or 4 (uncompressed), modulo 2^32.
REQ-017 SHALL, in ALIGNED with fetch word W[1:0]==2'b11, present W, set fetch_ready_o = instr_ready_i, and stay ALIGNED on transfer.
REQ-018 SHALL, in ALIGNED with W[1:0]!=2'b11, present {16'h0, W[15:0]}, set fetch_ready_o = instr_ready_i, and on transfer load residual with W[31:16] and go to HALF.
REQ-019 SHALL, in HALF with residual[1:0]!=2'b11, present {16'h0, residual} regardless of fetch_valid_i, hold fetch_ready_o low, and on transfer go to ALIGNED.
REQ-020 SHALL, in HALF with residual[1:0]==2'b11, present {W[15:0], residual} only when fetch_valid_i is high, set fetch_ready_o = instr_ready_i, and on transfer load residual with W[31:16] and stay in HALF.
REQ-021 SHALL, in SKIP_LOW with W[17:16]!=2'b11, present {16'h0, W[31:16]}, set fetch_ready_o = instr_ready_i, and on transfer go to ALIGNED.
REQ-022 SHALL, in SKIP_LOW with W[17:16]==2'b11, hold instr_valid_o low, assert fetch_ready_o regardless of instr_ready_i, and on fetch acceptance load residual with W[31:16] and go to HALF; pc is unchanged.
REQ-023 SHALL, while branch_i is high, force instr_valid_o and fetch_ready_o low, discard the residual, load pc with {branch_addr_i[31:1], 1'b0}, and go to SKIP_LOW if branch_addr_i[1] is 1, otherwise to ALIGNED.
REQ-024 SHALL give branch_i priority over any transfer in the same cycle; no pc increment occurs in that cycle.
REQ-025 SHALL hold instr_valid_o low whenever fetch_valid_i is low, except in HALF with a compressed residual.
REQ-026 SHALL keep all outputs stable while instr_valid_o is high and instr_ready_i is low, given stable fetch inputs.

Reset
REQ-027 SHALL, on rst_n low, asynchronously set state to ALIGNED, residual to 16'h0000 and pc to BOOT_ADDR.
REQ-028 SHALL, during and immediately after reset, drive instr_valid_o = 0, fetch_ready_o = 0 (until fetch_valid_i), and instr_addr_o = BOOT_ADDR.
REQ-029 SHALL, when reset is asserted mid-operation in any state, discard any pending residual instruction; no partial instruction is ever emitted after reset.

Verification
REQ-030 SHALL cover: after reset, words 32'h00A00093, 32'h00108113 with ready always high -> two uncompressed transfers at PCs 0x80 and 0x84, state remains ALIGNED.
REQ-031 SHALL cover: word 32'h4505_0505 -> {16'h0,16'h0505}@0x80, then {16'h0,16'h4505}@0x82 with fetch_ready_o low on the second transfer, then ALIGNED.
REQ-032 SHALL cover straddle: words 32'h0093_0505, 32'h1111_00A0 -> 16'h0505@0x80, then 32'h00A0_0093@0x82, residual 16'h1111, state HALF.
REQ-033 SHALL cover: branch to 0x102 followed by word 32'h0505_FFFF -> low half dropped, 16'h0505 emitted at PC 0x102, state ALIGNED.
REQ-034 SHALL cover: branch to 0x106 followed by word 32'h0093_xxxx -> no output while the word is consumed; next word 32'h0000_00A0 -> 32'h00A0_0093@0x106.
REQ-035 SHALL cover: branch_i asserted with instr_valid_o and instr_ready_i high -> no transfer and pc = target; then rst_n pulsed while in HALF -> instr_addr_o = 0x80, state ALIGNED.
